// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: mode and channel-state encodings shared by the tick timer bank.
package tick_timer_pkg;
    localparam logic [1:0] MODE_TICK    = 2'd0;
    localparam logic [1:0] MODE_TOGGLE  = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/tick_timer_ch.sv
// tick_timer_ch: one timer channel with its own period/mode registers, counter and output FSM.
module tick_timer_ch #(
    parameter int         CNT_W      = 32,
    parameter logic [CNT_W-1:0] RST_PERIOD = '0,
    parameter logic [1:0] RST_MODE   = 2'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             we,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             tick,
    output logic             done,
    output logic [CNT_W-1:0] count
);
    import tick_timer_pkg::*;
    logic [1:0]       st;
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic             terminal, toggle, oneshot;
    assign terminal = count == period - CNT_W'(1);
    assign toggle   = mode == MODE_TOGGLE;
    assign oneshot  = mode == MODE_ONESHOT;
    // IDLE with count 0 advances exactly like RUN, so the enabling edge is the first counted cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_IDLE;
            mode   <= RST_MODE;
            period <= RST_PERIOD;
            count  <= '0;
            tick   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (we) begin
                period <= cfg_period;
                mode   <= cfg_mode;
            end
            if (!enable || we || (clr && st != ST_IDLE)) begin
                count <= '0;
                tick  <= 1'b0;
                done  <= 1'b0;
                st    <= !enable ? ST_IDLE : we ? (cfg_period != '0 ? ST_RUN : ST_IDLE) : ST_RUN;
            end else if (st == ST_DONE || period == '0) begin
                tick <= 1'b0;
            end else if (terminal) begin
                count <= '0;
                tick  <= toggle ? ~tick : 1'b1;
                done  <= oneshot;
                st    <= oneshot ? ST_DONE : ST_RUN;
            end else begin
                count <= count + CNT_W'(1);
                tick  <= toggle & tick;
                st    <= ST_RUN;
            end
        end
    end
endmodule

// File: rtl/tick_timer_bank.sv
// tick_timer_bank: NUM_CH independent programmable tick/toggle/one-shot timers
// sharing one configuration port and a bank-wide phase clear.
module tick_timer_bank #(
    parameter int               NUM_CH     = 4,
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] RST_PERIOD = '0,
    parameter logic [1:0]       RST_MODE   = 2'd0,
    localparam int              CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_n_reset,
    input  logic [NUM_CH-1:0]       i_enable,
    input  logic                    i_sync_clear,
    input  logic                    i_cfg_we,
    input  logic [CH_W-1:0]         i_cfg_ch,
    input  logic [1:0]              i_cfg_mode,
    input  logic [CNT_W-1:0]        i_cfg_period,
    output logic [NUM_CH-1:0]       o_tick,
    output logic [NUM_CH-1:0]       o_done,
    output logic [NUM_CH*CNT_W-1:0] o_count
);
    import tick_timer_pkg::*;
    // An index beyond NUM_CH-1 matches no channel, so such writes are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_timer_ch #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_PERIOD),
            .RST_MODE   (RST_MODE)
        ) u_ch (
            .clk        (i_clk),
            .rst_n      (i_n_reset),
            .enable     (i_enable[g]),
            .clr        (i_sync_clear),
            .we         (i_cfg_we && i_cfg_ch == CH_W'(g)),
            .cfg_mode   (i_cfg_mode),
            .cfg_period (i_cfg_period),
            .tick       (o_tick[g]),
            .done       (o_done[g]),
            .count      (o_count[g*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_tick_timer_bank.sv
// tb_tick_timer_bank: table-driven directed check of the tick timer bank plus reset sequences.
module tb_tick_timer_bank;
    logic         i_clk = 1'b0;
    logic         i_n_reset = 1'b1;
    logic [3:0]   i_enable = '0;
    logic         i_sync_clear = 1'b0;
    logic         i_cfg_we = 1'b0;
    logic [1:0]   i_cfg_ch = '0;
    logic [1:0]   i_cfg_mode = '0;
    logic [31:0]  i_cfg_period = '0;
    logic [3:0]   o_tick;
    logic [3:0]   o_done;
    logic [127:0] o_count;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  en;
        logic        clr;
        logic        we;
        logic [1:0]  ch;
        logic [1:0]  mode;
        logic [31:0] period;
        logic [3:0]  tick;
        logic [3:0]  done;
        int          cch;
        logic [31:0] cnt;
    } vec_t;
    vec_t vecs[$];

    tick_timer_bank dut (
        .i_clk        (i_clk),
        .i_n_reset    (i_n_reset),
        .i_enable     (i_enable),
        .i_sync_clear (i_sync_clear),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_ch     (i_cfg_ch),
        .i_cfg_mode   (i_cfg_mode),
        .i_cfg_period (i_cfg_period),
        .o_tick       (o_tick),
        .o_done       (o_done),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] en, input logic clr, input logic we, input logic [1:0] ch,
                       input logic [1:0] mode, input logic [31:0] period, input logic [3:0] tick,
                       input logic [3:0] done, input int cch, input logic [31:0] cnt);
        vecs.push_back('{en, clr, we, ch, mode, period, tick, done, cch, cnt});
    endtask

    task automatic cycle();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        #2 i_n_reset = 1'b0;
        #1;
        check("reset_tick", o_tick, 0);
        check("reset_done", o_done, 0);
        check("reset_count", o_count, 0);
        @(negedge i_clk);
        i_n_reset = 1'b1;
        i_enable = 4'hF;
        for (int k = 0; k < 50; k++) begin
            cycle();
            check($sformatf("idle%0d_tick", k), o_tick, 0);
            check($sformatf("idle%0d_count", k), o_count, 0);
        end
        i_enable = '0;
        // ch0 tick mode, period 5
        add(0, 0, 1, 0, 0, 5, 0, 0, 0, 0);
        for (int k = 1; k <= 15; k++) add(4'b0001, 0, 0, 0, 0, 0, (k % 5 == 0) ? 4'b0001 : 4'b0000, 0, 0, k % 5);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ch1 toggle, period 3
        add(0, 0, 1, 1, 1, 3, 0, 0, 1, 0);
        for (int k = 1; k <= 9; k++) add(4'b0010, 0, 0, 0, 0, 0, ((k / 3) % 2 == 1) ? 4'b0010 : 4'b0000, 0, 1, k % 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // ch2 one-shot, period 4, fired twice
        add(0, 0, 1, 2, 2, 4, 0, 0, 2, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= (r == 0 ? 6 : 4); k++)
                add(4'b0100, 0, 0, 0, 0, 0, k == 4 ? 4'b0100 : 4'b0000, k >= 4 ? 4'b0100 : 4'b0000, 2, k < 4 ? k : 0);
            add(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        end
        // ch0 rewritten on its terminal cycle
        add(0, 0, 1, 0, 0, 5, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) add(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, k);
        add(4'b0001, 0, 1, 0, 0, 7, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) add(4'b0001, 0, 0, 0, 0, 0, k == 7 ? 4'b0001 : 4'b0000, 0, 0, k % 7);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ch3 period 1 holds tick high
        add(0, 0, 1, 3, 0, 1, 0, 0, 3, 0);
        for (int k = 1; k <= 3; k++) add(4'b1000, 0, 0, 0, 0, 0, 4'b1000, 0, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        // sync clear of ch0 (period 6) and ch1 (period 4)
        add(0, 0, 1, 0, 0, 6, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 4, 0, 0, 1, 0);
        for (int k = 1; k <= 3; k++) add(4'b0011, 0, 0, 0, 0, 0, 0, 0, 0, k);
        add(4'b0011, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 6; k++)
            add(4'b0011, 0, 0, 0, 0, 0, (k == 4 ? 4'b0010 : 4'b0000) | (k == 6 ? 4'b0001 : 4'b0000), 0, 0, k % 6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (vecs[i]) begin
            i_enable = vecs[i].en;
            i_sync_clear = vecs[i].clr;
            i_cfg_we = vecs[i].we;
            i_cfg_ch = vecs[i].ch;
            i_cfg_mode = vecs[i].mode;
            i_cfg_period = vecs[i].period;
            cycle();
            check($sformatf("vec%0d_tick", i), o_tick, vecs[i].tick);
            check($sformatf("vec%0d_done", i), o_done, vecs[i].done);
            check($sformatf("vec%0d_count%0d", i, vecs[i].cch), o_count[vecs[i].cch*32 +: 32], vecs[i].cnt);
        end
        i_sync_clear = 1'b0;
        i_cfg_we = 1'b0;
        // asynchronous reset in the middle of a toggle high phase
        i_enable = 4'b0010;
        i_cfg_we = 1'b1;
        i_cfg_ch = 2'd1;
        i_cfg_mode = 2'd1;
        i_cfg_period = 32'd3;
        cycle();
        i_cfg_we = 1'b0;
        repeat (4) cycle();
        check("pre_reset_tick", o_tick, 4'b0010);
        check("pre_reset_count1", o_count[63:32], 1);
        #2 i_n_reset = 1'b0;
        #1;
        check("async_reset_tick", o_tick, 0);
        check("async_reset_done", o_done, 0);
        check("async_reset_count", o_count, 0);
        cycle();
        check("held_reset_tick", o_tick, 0);
        check("held_reset_count", o_count, 0);
        i_n_reset = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_timer_bank.md
# tick_timer_bank

Multi-channel programmable tick/toggle/one-shot generator, the parametrised successor of the single-channel fixed-threshold wait counter. Each channel has its own runtime-writable period and mode, independent enable, and a shared synchronous phase-clear. It sits beside the joystick/SPI and display-timing logic and supplies sample strobes, blink clocks and timeouts from one block instead of many fixed-parameter instances.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 32, counter and period width
- RST_PERIOD, 0, period loaded into every channel at reset (0 = channel idle until configured)
- RST_MODE, 0, mode loaded into every channel at reset
- i_clk  in  1  sole clock, all state on rising edge
- i_n_reset  in  1  asynchronous, active-low reset
- i_enable  in  NUM_CH  per-channel run enable, level
- i_sync_clear  in  1  restart all channels from count 0 in the same cycle
- i_cfg_we  in  1  configuration write strobe, one cycle
- i_cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for write
- i_cfg_mode  in  2  0 tick, 1 toggle, 2 one-shot, 3 reserved (behaves as tick)
- i_cfg_period  in  CNT_W  period in cycles
- o_tick  out  NUM_CH  per-channel output (pulse or square wave per mode)
- o_done  out  NUM_CH  one-shot finished, sticky until enable falls
- o_count  out  NUM_CH*CNT_W  live counters, channel 0 in LSBs

## Operation
- Per channel state: count, period, mode, tick, done; channel FSM IDLE, RUN, DONE.
- IDLE: enable low or period 0; count=0, tick=0, done=0. Enable high with period≠0 -> RUN.
- RUN: count increments per cycle; at count==period-1 (terminal), count<=0 and:
  - tick mode: tick<=1 that cycle, 0 otherwise.
  - toggle mode: tick<=~tick; square wave of 2*period cycles.
  - one-shot: tick<=1 for one cycle, done<=1, -> DONE.
- DONE: count held 0, tick 0, done 1; leaves only when enable falls -> IDLE.
- Enable low in any state -> IDLE next edge (count, tick, done cleared; toggle phase lost).
- Config write to channel c: period and mode updated; c's count<=0, tick<=0, done<=0, state re-evaluated as from IDLE. Write beats a coincident terminal count (no event). Out-of-range i_cfg_ch ignored.
- i_sync_clear: every RUN/DONE channel count<=0, tick<=0, done<=0, back to RUN if enabled; lower priority than cfg write for the written channel, higher than terminal count.
- Period 1: tick mode o_tick constantly 1 while enabled; toggle flips every cycle; one-shot fires on first enabled cycle.
- Counter arithmetic modulo 2^CNT_W; never reaches wrap because terminal compare precedes it.

## Timing
- Reset: all counts 0, period=RST_PERIOD, mode=RST_MODE, o_tick=0, o_done=0, state IDLE.
- Outputs registered, no combinational path input->output.
- Enable sampled high at edge 1 with period P: first o_tick high after edge P, for one cycle (tick mode); then every P cycles.
- o_done rises in the same cycle as the one-shot tick pulse.
- Config write takes effect at next edge; first event P cycles after write edge if enabled.
- Reset mid-operation clears asynchronously regardless of clock.

## Structure
- Package tick_timer_pkg: mode constants (MODE_TICK, MODE_TOGGLE, MODE_ONESHOT), FSM state encoding.
- Sub-module tick_timer_ch: one channel (counter, FSM, output reg); bank instantiates NUM_CH via generate and decodes cfg writes/sync clear.

## Test plan
- Reset, RST_PERIOD=0, enable all -> o_tick=0, o_count=0 for 50 cycles.
- Ch0 period 5 tick mode, enable -> o_tick[0] one-cycle pulses at cycles 5,10,15 after enable.
- Ch1 period 3 toggle -> o_tick[1] high 3 / low 3, first rise at cycle 3; enable low -> 0 next cycle.
- Ch2 period 4 one-shot -> single pulse at cycle 4, o_done[2]=1 held; drop enable -> o_done 0; re-enable fires again at +4.
- Cfg write to ch0 period 7 on its terminal cycle -> no pulse, next pulse 7 cycles after write.
- Ch0 period 6, ch1 period 4 running, i_sync_clear -> both counts 0, pulses at +6 and +4; async reset mid-count clears all outputs immediately.
